// File: rtl/exe_mem_skid_buffer_pkg.sv
// Shared types and constants for the EXE->MEM skid-buffered stage register.
package exe_mem_skid_buffer_pkg;

    // Encodings double as the entry count driven on the occupancy port.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int CTRL_MEM_WRT = 0;
    localparam int CTRL_REG_WRT = 1;

    localparam int DEF_BIT_WIDTH           = 32;
    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
    localparam int DEF_CTRL_WIDTH          = 2;

endpackage

// File: rtl/exe_mem_skid_buffer_reg.sv
// Enable-gated register with asynchronous active-high reset; one instance per buffer entry.
module exe_mem_skid_buffer_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/exe_mem_skid_buffer.sv
// EXE->MEM stage register: valid/ready handshake, two-entry skid buffer, synchronous flush.
module exe_mem_skid_buffer
    import exe_mem_skid_buffer_pkg::*;
#(
    parameter int BIT_WIDTH           = DEF_BIT_WIDTH,
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int CTRL_WIDTH          = DEF_CTRL_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src1_in,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in,
    input  logic [BIT_WIDTH-1:0]           alu_res_in,
    input  logic [CTRL_WIDTH-1:0]          ctrl_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [REG_INDEX_BIT_WIDTH-1:0] src1_out,
    output logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_out,
    output logic [BIT_WIDTH-1:0]           alu_res_out,
    output logic [CTRL_WIDTH-1:0]          ctrl_out,
    output logic [1:0]                     occupancy
);

    localparam int PW = 2 * REG_INDEX_BIT_WIDTH + BIT_WIDTH + CTRL_WIDTH;

    state_e        state_q, state_d;
    logic          in_ready_q, out_valid_q;
    logic          push, pop;
    logic          main_en, skid_en;
    logic [PW-1:0] in_word, main_d, main_q, skid_d, skid_q;
    logic [PW-1:0] main_cleared, skid_cleared;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    assign in_word = {src1_in, dst_ind_in, alu_res_in, ctrl_in};

    // Squashed or drained entries keep stale data but lose their control bits.
    assign main_cleared = {main_q[PW-1:CTRL_WIDTH], {CTRL_WIDTH{1'b0}}};
    assign skid_cleared = {skid_q[PW-1:CTRL_WIDTH], {CTRL_WIDTH{1'b0}}};

    // in_ready and out_valid are registered decodes of the next state, so neither
    // out_ready nor in_valid has a combinational path to in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = TWO;
                    else if (!push && pop) state_d = EMPTY;
                end
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_en = 1'b0;
        main_d  = in_word;
        skid_en = 1'b0;
        skid_d  = in_word;
        if (flush) begin
            main_en = 1'b1;
            main_d  = main_cleared;
            skid_en = 1'b1;
            skid_d  = skid_cleared;
        end else begin
            case (state_q)
                EMPTY: main_en = push;
                ONE: begin
                    if (push && pop) begin
                        main_en = 1'b1;
                    end else if (push) begin
                        skid_en = 1'b1;
                    end else if (pop) begin
                        main_en = 1'b1;
                        main_d  = main_cleared;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        skid_en = 1'b1;
                        skid_d  = skid_cleared;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: payload storage is reset as well so outputs come up at zero, not X.
    exe_mem_skid_buffer_reg #(.WIDTH(PW)) u_main (
        .clk  (clk),
        .reset(reset),
        .en   (main_en),
        .d    (main_d),
        .q    (main_q)
    );

    exe_mem_skid_buffer_reg #(.WIDTH(PW)) u_skid (
        .clk  (clk),
        .reset(reset),
        .en   (skid_en),
        .d    (skid_d),
        .q    (skid_q)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign occupancy   = state_q;
    assign src1_out    = main_q[PW-1 -: REG_INDEX_BIT_WIDTH];
    assign dst_ind_out = main_q[PW-1-REG_INDEX_BIT_WIDTH -: REG_INDEX_BIT_WIDTH];
    assign alu_res_out = main_q[CTRL_WIDTH +: BIT_WIDTH];
    assign ctrl_out    = out_valid_q ? main_q[CTRL_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_exe_mem_skid_buffer.sv
// Self-checking bench for exe_mem_skid_buffer: directed vector table, async reset, random scoreboard run.
module tb_exe_mem_skid_buffer;
    import exe_mem_skid_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  src1_in, dst_ind_in, src1_out, dst_ind_out;
    logic [31:0] alu_res_in, alu_res_out;
    logic [1:0]  ctrl_in, ctrl_out, occupancy;

    int total = 0;
    int bad   = 0;

    exe_mem_skid_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src1_in    (src1_in),
        .dst_ind_in (dst_ind_in),
        .alu_res_in (alu_res_in),
        .ctrl_in    (ctrl_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src1_out   (src1_out),
        .dst_ind_out(dst_ind_out),
        .alu_res_out(alu_res_out),
        .ctrl_out   (ctrl_out),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        rdy;
        logic        fl;
        logic [31:0] alu;
        logic [1:0]  ctrl;
        logic        e_ov;
        logic [31:0] e_alu;
        logic [1:0]  e_ctrl;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [1:0]  ctrl;
    } ent_t;

    vec_t vecs[18];
    ent_t sb[$];
    ent_t ent;
    logic m_push, m_pop, m_ov;
    logic [3:0] e_nib;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic rdy, input logic fl,
                         input logic [31:0] alu, input logic [1:0] ctrl);
        in_valid   = iv;
        out_ready  = rdy;
        flush      = fl;
        alu_res_in = alu;
        ctrl_in    = ctrl;
        src1_in    = alu[3:0];
        dst_ind_in = alu[7:4];
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".ctrl_out"},  {30'd0, ctrl_out},  32'd0);
        check({tag, ".occupancy"}, {30'd0, occupancy}, 32'd0);
        check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        //           iv   rdy  fl   alu    ctrl   e_ov e_alu  e_ctrl e_occ e_ir
        vecs[0]  = '{1'b1,1'b1,1'b0,32'h01,2'b01, 1'b1,32'h01,2'b01, 2'd1, 1'b1}; // stream
        vecs[1]  = '{1'b1,1'b1,1'b0,32'h02,2'b10, 1'b1,32'h02,2'b10, 2'd1, 1'b1};
        vecs[2]  = '{1'b1,1'b1,1'b0,32'h03,2'b00, 1'b1,32'h03,2'b00, 2'd1, 1'b1};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h00,2'b00, 1'b0,32'h00,2'b00, 2'd0, 1'b1};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'h0A,2'b01, 1'b1,32'h0A,2'b01, 2'd1, 1'b1}; // back-pressure
        vecs[5]  = '{1'b1,1'b0,1'b0,32'h0B,2'b10, 1'b1,32'h0A,2'b01, 2'd2, 1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h0D,2'b11, 1'b1,32'h0A,2'b01, 2'd2, 1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,32'h00,2'b00, 1'b1,32'h0B,2'b10, 2'd1, 1'b1};
        vecs[8]  = '{1'b0,1'b1,1'b0,32'h00,2'b00, 1'b0,32'h00,2'b00, 2'd0, 1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,32'h10,2'b11, 1'b1,32'h10,2'b11, 2'd1, 1'b1}; // flush in TWO
        vecs[10] = '{1'b1,1'b0,1'b0,32'h11,2'b01, 1'b1,32'h10,2'b11, 2'd2, 1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,32'h0C,2'b11, 1'b0,32'h00,2'b00, 2'd0, 1'b1};
        vecs[12] = '{1'b0,1'b1,1'b0,32'h00,2'b00, 1'b0,32'h00,2'b00, 2'd0, 1'b1};
        vecs[13] = '{1'b1,1'b0,1'b0,32'h20,2'b11, 1'b1,32'h20,2'b11, 2'd1, 1'b1}; // flush in ONE
        vecs[14] = '{1'b1,1'b1,1'b1,32'h21,2'b11, 1'b0,32'h00,2'b00, 2'd0, 1'b1};
        vecs[15] = '{1'b0,1'b1,1'b0,32'h00,2'b00, 1'b0,32'h00,2'b00, 2'd0, 1'b1};
        vecs[16] = '{1'b1,1'b1,1'b0,32'h30,2'b10, 1'b1,32'h30,2'b10, 2'd1, 1'b1}; // refill
        vecs[17] = '{1'b0,1'b1,1'b0,32'h00,2'b00, 1'b0,32'h00,2'b00, 2'd0, 1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
        #12;
        check_idle("reset");
        check("reset.alu_res_out", alu_res_out, 32'h0);
        check("reset.src1_out", {28'd0, src1_out}, 32'h0);
        check("reset.dst_ind_out", {28'd0, dst_ind_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].rdy, vecs[i].fl, vecs[i].alu, vecs[i].ctrl);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d.ctrl_out", i),  {30'd0, ctrl_out},  {30'd0, vecs[i].e_ctrl});
            check($sformatf("vec%0d.occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
            check($sformatf("vec%0d.in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            check($sformatf("vec%0d.mem_wrt_en", i), {31'd0, ctrl_out[CTRL_MEM_WRT]},
                  {31'd0, vecs[i].e_ctrl[CTRL_MEM_WRT]});
            if (vecs[i].e_ov) begin
                e_nib = vecs[i].e_alu[3:0];
                check($sformatf("vec%0d.alu_res_out", i), alu_res_out, vecs[i].e_alu);
                check($sformatf("vec%0d.src1_out", i), {28'd0, src1_out}, {28'd0, e_nib});
                e_nib = vecs[i].e_alu[7:4];
                check($sformatf("vec%0d.dst_ind_out", i), {28'd0, dst_ind_out}, {28'd0, e_nib});
            end
        end

        // Asynchronous reset asserted between edges while stalled with two entries.
        drive(1'b1, 1'b0, 1'b0, 32'h40, 2'b11);
        @(posedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h41, 2'b11);
        @(posedge clk);
        #1;
        check("stall.occupancy", {30'd0, occupancy}, 32'd2);
        check("stall.in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset.alu_res_out", alu_res_out, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle("post_reset");

        // Random valid/ready/flush traffic against a queue model.
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            ent.alu  = $urandom;
            ent.ctrl = 2'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ent.alu, ent.ctrl);
            m_push = in_valid && (sb.size() < 2);
            m_pop  = out_ready && (sb.size() > 0);
            @(posedge clk);
            #1;
            if (flush) begin
                sb.delete();
            end else begin
                if (m_pop)  void'(sb.pop_front());
                if (m_push) sb.push_back(ent);
            end
            m_ov = (sb.size() > 0);
            check("rand.out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            check("rand.occupancy", {30'd0, occupancy}, sb.size());
            check("rand.in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
            if (m_ov) begin
                check("rand.alu_res_out", alu_res_out, sb[0].alu);
                check("rand.ctrl_out", {30'd0, ctrl_out}, {30'd0, sb[0].ctrl});
            end else begin
                check("rand.ctrl_out_idle", {30'd0, ctrl_out}, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
